// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: streams operand bits LSB first through one full-adder
// cell with a registered carry, producing {cout,sum} = a + b + cin after WIDTH cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_sr_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s_d;
    logic             fa_c_d;
    logic [WIDTH-1:0] res_sr_d;

    // The single full-adder cell shared by every bit position.
    always_comb begin
        fa_s_d   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        fa_c_d   = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
        res_sr_d = {fa_s_d, res_sr_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q   <= a;
                        b_sr_q   <= b;
                        carry_q  <= cin;
                        res_sr_q <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    res_sr_q <= res_sr_d;
                    carry_q  <= fa_c_d;
                    cnt_q    <= cnt_q + CW'(1);
                    // Last bit: publish the result including the bit computed this edge.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum_q   <= res_sr_d;
                        cout_q  <= fa_c_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus handshake, abort and
// back-to-back sequences with hand-computed expected results.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int checks = 0;
    int errors = 0;

    logic [7:0] prev_sum;
    logic       prev_cout;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[10];

    serial_adder #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Called at E0+1: walks edges E1..E8 and one edge beyond, checking the handshake.
    task automatic finish_op(input logic [7:0] es, input logic ec);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i < 8) begin
                chk("busy_run", busy, 1);
                chk("done_run", done, 0);
                chk("sum_hold", sum, prev_sum);
                chk("cout_hold", cout, prev_cout);
            end else begin
                chk("done_pulse", done, 1);
                chk("busy_at_done", busy, 0);
                chk("sum", sum, es);
                chk("cout", cout, ec);
            end
        end
        @(posedge clk); #1;
        chk("done_width", done, 0);
        chk("busy_after", busy, 0);
        prev_sum  = es;
        prev_cout = ec;
    endtask

    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input logic [7:0] es, input logic ec);
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(posedge clk); #1;
        chk("busy_accept", busy, 1);
        start = 1'b0;
        a = ~va; b = ~vb; cin = ~vc;
        finish_op(es, ec);
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0};
        vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0};
        vecs[8] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};
        vecs[9] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_start", busy, 0);

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout);

        // Start and operand changes while busy are ignored
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        chk("ign_accept", busy, 1);
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 2) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end
            if (i == 3) start = 1'b0;
            if (i < 8) chk("ign_busy", busy, 1);
        end
        chk("ign_done", done, 1);
        chk("ign_sum", sum, 8'h46);
        chk("ign_cout", cout, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("ign_no_second_done", done, 0);
            chk("ign_no_second_busy", busy, 0);
        end
        prev_sum = 8'h46; prev_cout = 1'b0;

        // Reset mid-operation, released while start is held
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        chk("rst_hold_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_accept", busy, 1);
        start = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;
        finish_op(8'h00, 1'b1);

        // Back-to-back with start held high: completions 10 cycles apart
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_accept1", busy, 1);
        a = 8'h10; b = 8'h20;
        finish_op(8'h03, 1'b0);
        @(posedge clk); #1;
        chk("b2b_accept2", busy, 1);
        start = 1'b0;
        finish_op(8'h30, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
